stopwatch_ctrl: RTL

- Control FSM that sequences the BCD stopwatch datapath from three front-panel buttons.
- Synchronizes and edge-detects the buttons, then owns the run/pause/countdown/expiry state.
- Generates the tenth-second count enable from the system clock.
- Drives the datapath's enable, direction, clear and preset-load controls; the datapath only counts.

---
 rtl/stopwatch_ctrl_if.sv | 46 ++++
 rtl/stopwatch_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Control/status bundle between the stopwatch controller, the front panel and the BCD datapath.
// The master side is the controller; the slave side is the panel plus datapath.
interface stopwatch_ctrl_if;
  logic        btn_startstop;
  logic        btn_clear;
  logic        btn_mode;
  logic [11:0] preset_bcd;
  logic        count_zero;
  logic        count_en;
  logic        count_down;
  logic        clear;
  logic        load;
  logic [11:0] load_value;
  logic [1:0]  state;
  logic        expired;

  modport master (
    input  btn_startstop,
    input  btn_clear,
    input  btn_mode,
    input  preset_bcd,
    input  count_zero,
    output count_en,
    output count_down,
    output clear,
    output load,
    output load_value,
    output state,
    output expired
  );

  modport slave (
    output btn_startstop,
    output btn_clear,
    output btn_mode,
    output preset_bcd,
    output count_zero,
    input  count_en,
    input  count_down,
    input  clear,
    input  load,
    input  load_value,
    input  state,
    input  expired
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button sync/edge detect, run/pause/countdown/expiry sequencing and
// tenth-second tick generation for the BCD datapath.
module stopwatch_ctrl #(
  parameter int unsigned TICK_DIV = 10000000,
  parameter int unsigned PRE_W    = 24
) (
  input logic              clk,
  input logic              reset,
  stopwatch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_DIV - 1);

  // Button order in the vectors below: {mode, clear, startstop}
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q, hist_q, press_q;
  logic [1:0] fill_q;
  logic       ss_p, clr_p, mode_p;

  assign btn_raw = {bus.btn_mode, bus.btn_clear, bus.btn_startstop};

  // History holds at 1 until the synchronizer has refilled after reset, so a button held
  // through reset never looks like a fresh rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      hist_q  <= '1;
      press_q <= '0;
      fill_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      press_q <= sync2_q & ~hist_q;
      if (fill_q != 2'd2) begin
        fill_q <= fill_q + 2'd1;
      end else begin
        hist_q <= sync2_q;
      end
    end
  end

  assign ss_p   = press_q[0];
  assign clr_p  = press_q[1];
  assign mode_p = press_q[2];

  state_e           state_q;
  logic             count_down_q;
  logic             count_en_q;
  logic             clear_q;
  logic             load_q;
  logic             expired_q;
  logic [11:0]      load_value_q;
  logic [PRE_W-1:0] pre_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      count_down_q <= 1'b0;
      count_en_q   <= 1'b0;
      clear_q      <= 1'b0;
      load_q       <= 1'b0;
      expired_q    <= 1'b0;
      load_value_q <= '0;
      pre_q        <= '0;
    end else begin
      count_en_q <= 1'b0;
      clear_q    <= 1'b0;
      load_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (clr_p) begin
            clear_q <= 1'b1;
          end else if (ss_p) begin
            if (!count_down_q) begin
              state_q <= StRun;
              pre_q   <= '0;
            end else if (bus.preset_bcd != 12'h000) begin
              load_q       <= 1'b1;
              load_value_q <= bus.preset_bcd;
              state_q      <= StRun;
              pre_q        <= '0;
            end
          end else if (mode_p) begin
            count_down_q <= ~count_down_q;
          end
        end
        StRun: begin
          if (clr_p) begin
            clear_q <= 1'b1;
            state_q <= StIdle;
            pre_q   <= '0;
          // count_zero still reflects the pre-load count while the load strobe is in flight.
          end else if (count_down_q && bus.count_zero && !load_q) begin
            state_q   <= StExpired;
            expired_q <= 1'b1;
          end else if (ss_p) begin
            state_q <= StPause;
          end else if (pre_q == PreLast) begin
            count_en_q <= 1'b1;
            pre_q      <= '0;
          end else begin
            pre_q <= pre_q + PRE_W'(1);
          end
        end
        StPause: begin
          if (clr_p) begin
            clear_q <= 1'b1;
            state_q <= StIdle;
            pre_q   <= '0;
          end else if (ss_p) begin
            state_q <= StRun;
          end
        end
        StExpired: begin
          if (clr_p || ss_p) begin
            clear_q   <= 1'b1;
            expired_q <= 1'b0;
            state_q   <= StIdle;
            pre_q     <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.count_en   = count_en_q;
  assign bus.count_down = count_down_q;
  assign bus.clear      = clear_q;
  assign bus.load       = load_q;
  assign bus.load_value = load_value_q;
  assign bus.state      = state_q;
  assign bus.expired    = expired_q;

`ifndef SYNTHESIS
  a_load_clear_excl: assert property (@(posedge clk) disable iff (!reset)
    !(load_q && clear_q));
  a_expired_state: assert property (@(posedge clk) disable iff (!reset)
    expired_q == (state_q == StExpired));
  a_en_only_run: assert property (@(posedge clk) disable iff (!reset)
    count_en_q |-> state_q == StRun);
  a_down_stable: assert property (@(posedge clk) disable iff (!reset)
    state_q != StIdle |=> $stable(count_down_q));
`endif

endmodule
